vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator: derives a pixel-rate clock enable from the system clock, runs horizontal/vertical counters over a programmable mode, and emits pixel coordinates, an active-video flag, sync pulses of selectable polarity and a frame-start strobe. Sync/valid outputs can be delayed by a programmable number of pixel ticks to align with pipelined colour logic. It replaces the fixed divide-by-2 clock and fixed-mode sync generator in the top-level VGA path; colour logic consumes `X`, `Y` and `PIX_EN`.

## Interface
- `DIV`, 2: system clocks per pixel; ≥1
- `H_ACTIVE`, 800; `H_FP`, 56; `H_SYNC`, 120; `H_BP`, 64: horizontal timing in pixels
- `V_ACTIVE`, 600; `V_FP`, 37; `V_SYNC`, 6; `V_BP`, 23: vertical timing in lines
- `HS_POL`, 1; `VS_POL`, 1: active level of `VGA_HS` / `VGA_VS`
- `PIPE`, 0: extra pixel-tick delay on `VGA_HS`, `VGA_VS`, `valid`; 0..15
- `CLOCK_100` in 1: system clock; all logic on rising edge
- `RST_N` in 1: asynchronous reset, active low
- `PIX_EN` out 1: pixel clock enable, one `CLOCK_100` cycle wide
- `X` out `P_WIDTH`: horizontal counter of current pixel
- `Y` out `P_WIDTH`: vertical counter of current pixel
- `valid` out 1: pixel is in the active region (delayed by `PIPE`)
- `VGA_HS`, `VGA_VS` out 1: sync outputs (delayed by `PIPE`)
- `frame_start` out 1: one-cycle strobe on the tick of pixel (0,0), undelayed

## Operation
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`; `V_TOTAL` likewise. Both must fit in `P_WIDTH`.
- Divider `div_cnt` counts 0..DIV-1 and wraps. `PIX_EN` = (`div_cnt == DIV-1`), combinational from the register. With DIV=1, `PIX_EN` is constantly 1 after reset.
- Each edge with `PIX_EN=1` is a pixel tick. On a tick, `hcnt` increments and wraps at `H_TOTAL-1`→0. `vcnt` increments only when `hcnt` wraps, and wraps at `V_TOTAL-1`→0.
- Region order per line/frame: active, front porch, sync, back porch. Horizontal sync is active for `H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC`. Vertical sync uses the same rule on `vcnt`.
- On each tick, registered outputs load from the pre-increment counters:
  - `X=hcnt`, `Y=vcnt`
  - raw_valid = (`hcnt<H_ACTIVE && vcnt<V_ACTIVE`)
  - raw HS/VS per the sync rule, at the `HS_POL`/`VS_POL` level
- `X`/`Y` are not masked outside the active region.
- raw_valid, raw HS and raw VS pass through a `PIPE`-deep shift register that advances only on ticks. With PIPE=0 the registered values drive the outputs directly.
- `frame_start` is a register set to 1 on the tick where `hcnt==0 && vcnt==0`, and cleared on every other edge.
- No runtime configuration; the mode is fixed at elaboration.

## Timing
- Reset (async assert, any cycle):
  - `div_cnt`, `hcnt`, `vcnt`, `X`, `Y` = 0
  - `valid`, `frame_start` = 0
  - `VGA_HS` = ~HS_POL, `VGA_VS` = ~VS_POL
  - all pipe stages hold inactive values
- Mid-frame reset: the frame is abandoned. After release, timing restarts at pixel (0,0) with no partial-line artefacts.
- The first `PIX_EN` is on the DIV-th rising edge after `RST_N` deasserts. The first tick loads pixel (0,0) and pulses `frame_start`.
- Latency:
  - `X`/`Y`/`frame_start`: 1 tick after the counter value
  - HS/VS/valid: 1+PIPE ticks
  - Outputs hold between ticks.
- Simultaneous `hcnt` wrap and `vcnt` wrap: both counters go to 0 on the same tick, with no extra line.
- Frame period is exactly `H_TOTAL*V_TOTAL*DIV` system clocks.

## Structure
- `vga_params.v` holds `P_WIDTH`, `D_WIDTH` and the default mode constants (800x600@72 values above). Parameter defaults reference these constants.
- One sub-module, `pixel_delay_line`: `PIPE`-deep, enable-gated, reset-to-value shift register. Instantiated for valid/HS/VS as one 3-bit vector, with a reset value of {0, ~HS_POL, ~VS_POL}.
- Counters, divider and region decode live in `vga_timing_gen`.

## Test plan
Mode for all scenarios unless noted: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), DIV=2, PIPE=0, HS_POL=VS_POL=0.

- Reset release → `PIX_EN` high on 2nd edge then every 2 cycles; `frame_start` pulses on that first tick; X=0, Y=0, `valid`=1.
- Full line → `valid` high for 8 ticks (X=0..7); `VGA_HS`=0 for exactly the 3 ticks where X=10..12; X wraps 15→0 while Y steps +1.
- Full frame → `VGA_VS`=0 on lines Y=5,6; `valid`=0 on Y≥4; `frame_start` period = 256 system clocks; pulses are exactly 1 cycle wide.
- PIPE=3 → `valid`/`VGA_HS` edges shift by exactly 3 ticks (6 clocks) relative to PIPE=0, while X/Y are unchanged. DIV=1 → `PIX_EN` constant 1 and frame = 128 clocks.
- `RST_N` asserted mid-line at X=5, Y=2, held 3 cycles → all outputs return to reset values immediately. Release → restart at (0,0) with `frame_start` on the first tick.
- HS_POL=VS_POL=1 → sync pulses are high, idle low, including during reset.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared widths, default 800x600@72 mode constants and region-decode helper.
// Pure declarations; no logic, no latency.
// No flow control; consumed at elaboration only.
package vga_timing_gen_pkg;

  // Counter width must cover H_TOTAL-1 and V_TOTAL-1 of any supported mode.
  localparam int unsigned P_WIDTH = 11;
  // Divider width; DIV may be at most 2**D_WIDTH.
  localparam int unsigned D_WIDTH = 8;

  localparam int unsigned DEF_DIV      = 2;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 56;
  localparam int unsigned DEF_H_SYNC   = 120;
  localparam int unsigned DEF_H_BP     = 64;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 37;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 23;
  localparam bit          DEF_HS_POL   = 1'b1;
  localparam bit          DEF_VS_POL   = 1'b1;
  localparam int unsigned DEF_PIPE     = 0;

  // True while cnt lies in [lo, lo+len): the sync window follows active + front porch.
  function automatic logic in_window(input logic [P_WIDTH-1:0] cnt,
                                     input int unsigned lo,
                                     input int unsigned len);
    return (32'(cnt) >= lo) && (32'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/pixel_delay_line.sv
// Enable-gated shift register, DEPTH stages deep, resetting to RST_VAL.
// Latency: DEPTH enabled cycles (DEPTH=0 is a plain wire).
// No backpressure; advances only when en_i is high, holds otherwise.
module pixel_delay_line #(
  parameter int unsigned          WIDTH   = 1,
  parameter int unsigned          DEPTH   = 0,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    // Clock, reset and enable are irrelevant without storage.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per pixel tick; reset loads the inactive pattern everywhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel enable divider, h/v counters, coordinates, sync, valid, frame strobe.
// Latency: X/Y/frame_start 1 tick after counter; HS/VS/valid 1+PIPE ticks.
// No backpressure; free-running, outputs hold between pixel ticks.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = DEF_HS_POL,
  parameter bit          VS_POL   = DEF_VS_POL,
  parameter int unsigned PIPE     = DEF_PIPE
) (
  input  logic               CLOCK_100,
  input  logic               RST_N,
  output logic               PIX_EN,
  output logic [P_WIDTH-1:0] X,
  output logic [P_WIDTH-1:0] Y,
  output logic               valid,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [D_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [P_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [P_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic               raw_valid_q, raw_valid_d;
  logic               raw_hs_q, raw_hs_d, raw_vs_q, raw_vs_d;
  logic               frame_start_q, frame_start_d;
  logic               tick, h_last, v_last;

  // With DIV=1 the divider sits at 0 == DIV-1, so every edge is a tick.
  assign tick   = (div_cnt_q == D_WIDTH'(DIV - 1));
  assign h_last = (hcnt_q == P_WIDTH'(H_TOTAL - 1));
  assign v_last = (vcnt_q == P_WIDTH'(V_TOTAL - 1));

  // Next state: counters advance and outputs sample the pre-increment counters on ticks.
  always_comb begin
    div_cnt_d     = tick ? '0 : div_cnt_q + D_WIDTH'(1);
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    x_d           = x_q;
    y_d           = y_q;
    raw_valid_d   = raw_valid_q;
    raw_hs_d      = raw_hs_q;
    raw_vs_d      = raw_vs_q;
    frame_start_d = 1'b0;
    if (tick) begin
      hcnt_d = h_last ? '0 : hcnt_q + P_WIDTH'(1);
      if (h_last) vcnt_d = v_last ? '0 : vcnt_q + P_WIDTH'(1);
      x_d           = hcnt_q;
      y_d           = vcnt_q;
      raw_valid_d   = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
      raw_hs_d      = in_window(hcnt_q, H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
      raw_vs_d      = in_window(vcnt_q, V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  // State registers; reset abandons the frame and parks syncs at their idle level.
  always_ff @(posedge CLOCK_100 or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q     <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      raw_valid_q   <= 1'b0;
      raw_hs_q      <= ~HS_POL;
      raw_vs_q      <= ~VS_POL;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      raw_valid_q   <= raw_valid_d;
      raw_hs_q      <= raw_hs_d;
      raw_vs_q      <= raw_vs_d;
      frame_start_q <= frame_start_d;
    end
  end

  pixel_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE),
    .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
  ) u_delay (
    .clk_i  (CLOCK_100),
    .rst_ni (RST_N),
    .en_i   (tick),
    .d_i    ({raw_valid_q, raw_hs_q, raw_vs_q}),
    .q_o    ({valid, VGA_HS, VGA_VS})
  );

  assign PIX_EN      = tick;
  assign X           = x_q;
  assign Y           = y_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: four instances (base, PIPE=3, DIV=1, positive sync).
// All share clock and reset; checks sampled 1 time unit after each rising edge.
// Expected values are computed from the small test mode H 8/2/3/3, V 4/1/2/1.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int c = 0;

  logic pe_a, v_a, hs_a, vs_a, fs_a;  logic [P_WIDTH-1:0] x_a, y_a;
  logic pe_b, v_b, hs_b, vs_b, fs_b;  logic [P_WIDTH-1:0] x_b, y_b;
  logic pe_c, v_c, hs_c, vs_c, fs_c;  logic [P_WIDTH-1:0] x_c, y_c;
  logic pe_d, v_d, hs_d, vs_d, fs_d;  logic [P_WIDTH-1:0] x_d, y_d;

  vga_timing_gen #(.DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(0)) u_a (
    .CLOCK_100(clk), .RST_N(rst_n), .PIX_EN(pe_a), .X(x_a), .Y(y_a), .valid(v_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .frame_start(fs_a));

  vga_timing_gen #(.DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(3)) u_b (
    .CLOCK_100(clk), .RST_N(rst_n), .PIX_EN(pe_b), .X(x_b), .Y(y_b), .valid(v_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .frame_start(fs_b));

  vga_timing_gen #(.DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(0)) u_c (
    .CLOCK_100(clk), .RST_N(rst_n), .PIX_EN(pe_c), .X(x_c), .Y(y_c), .valid(v_c),
    .VGA_HS(hs_c), .VGA_VS(vs_c), .frame_start(fs_c));

  vga_timing_gen #(.DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(0)) u_d (
    .CLOCK_100(clk), .RST_N(rst_n), .PIX_EN(pe_d), .X(x_d), .Y(y_d), .valid(v_d),
    .VGA_HS(hs_d), .VGA_VS(vs_d), .frame_start(fs_d));

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  // Reset values on every instance, including positive-polarity idle-low syncs.
  task automatic test_reset();
    logic [9:0] got_a, got_d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got_a = {pe_a, v_a, hs_a, vs_a, fs_a, x_a == '0, y_a == '0, v_b, hs_b, vs_b};
    checks++; if (got_a !== 10'b0011011011) begin failures++;
      $display("FAIL reset_base got=%b want=%b", got_a, 10'b0011011011); end
    got_d = {pe_d, v_d, hs_d, vs_d, fs_d, x_d == '0, y_d == '0, v_c, hs_c, vs_c};
    checks++; if (got_d !== 10'b0000011011) begin failures++;
      $display("FAIL reset_pos_pol got=%b want=%b", got_d, 10'b0000011011); end
    checks++; if (pe_c !== 1'b1) begin failures++;
      $display("FAIL reset_div1_pixen got=%b want=1", pe_c); end
  endtask

  // First two edges after release: enable on edge 1, first tick on edge 2 loads (0,0).
  task automatic test_release();
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    step();
    checks++; if ({pe_a, fs_a} !== 2'b10) begin failures++;
      $display("FAIL release_edge1 pix_en,fs got=%b want=10", {pe_a, fs_a}); end
    step();
    checks++; if ({pe_a, fs_a, v_a, hs_a, vs_a} !== 5'b01111) begin failures++;
      $display("FAIL release_edge2 pix_en,fs,valid,hs,vs got=%b want=01111", {pe_a, fs_a, v_a, hs_a, vs_a}); end
    checks++; if (x_a !== '0 || y_a !== '0) begin failures++;
      $display("FAIL release_xy got=%0d,%0d want=0,0", x_a, y_a); end
  endtask

  // Two whole frames, every cycle: line/frame regions, pipe shift, DIV=1, polarity.
  task automatic test_frames();
    int n, x, y, nb, xb, yb, nc, xc, yc;
    logic ev, ehs, evs, ebv, ebh;
    int fa_q[$];
    int fc_q[$];
    while (c < 514) begin
      step();
      n = c / 2 - 1; x = n % 16; y = (n / 16) % 8;
      ev  = (x < 8) && (y < 4);
      ehs = !((x >= 10) && (x <= 12));
      evs = !((y == 5) || (y == 6));
      checks++; if (x_a !== P_WIDTH'(x) || y_a !== P_WIDTH'(y)) begin failures++;
        $display("FAIL frame_xy c=%0d got=%0d,%0d want=%0d,%0d", c, x_a, y_a, x, y); end
      checks++; if ({v_a, hs_a, vs_a} !== {ev, ehs, evs}) begin failures++;
        $display("FAIL frame_regions c=%0d valid,hs,vs got=%b want=%b", c, {v_a, hs_a, vs_a}, {ev, ehs, evs}); end
      checks++; if (pe_a !== 1'(c % 2)) begin failures++;
        $display("FAIL frame_pixen c=%0d got=%b want=%b", c, pe_a, 1'(c % 2)); end
      checks++; if (fs_a !== ((c % 2 == 0) && x == 0 && y == 0)) begin failures++;
        $display("FAIL frame_start_a c=%0d got=%b", c, fs_a); end
      if (fs_a === 1'b1) fa_q.push_back(c);
      checks++; if ({hs_d, vs_d} !== {!ehs, !evs}) begin failures++;
        $display("FAIL pos_pol c=%0d got=%b want=%b", c, {hs_d, vs_d}, {!ehs, !evs}); end
      nb = n - 3; xb = nb % 16; yb = (nb / 16) % 8;
      ebv = (nb >= 0) && (xb < 8) && (yb < 4);
      ebh = (nb < 0) || !((xb >= 10) && (xb <= 12));
      checks++; if ({v_b, hs_b} !== {ebv, ebh} || x_b !== P_WIDTH'(x) || y_b !== P_WIDTH'(y)) begin
        failures++;
        $display("FAIL pipe3 c=%0d valid,hs got=%b want=%b x=%0d y=%0d", c, {v_b, hs_b}, {ebv, ebh}, x_b, y_b); end
      nc = c - 1; xc = nc % 16; yc = (nc / 16) % 8;
      checks++; if (x_c !== P_WIDTH'(xc) || y_c !== P_WIDTH'(yc) || pe_c !== 1'b1) begin failures++;
        $display("FAIL div1 c=%0d got x=%0d y=%0d pe=%b want %0d,%0d,1", c, x_c, y_c, pe_c, xc, yc); end
      checks++; if (fs_c !== (nc % 128 == 0)) begin failures++;
        $display("FAIL div1_frame_start c=%0d got=%b", c, fs_c); end
      if (fs_c === 1'b1) fc_q.push_back(c);
    end
    checks++; if (fa_q.size() != 2 || (fa_q.size() == 2 && (fa_q[0] != 258 || fa_q[1] != 514))) begin
      failures++; $display("FAIL frame_period_div2 pulses=%0d want 2 at 258,514", fa_q.size()); end
    checks++; if (fc_q.size() != 4 || (fc_q.size() == 4 && (fc_q[1] - fc_q[0] != 128 || fc_q[3] - fc_q[2] != 128))) begin
      failures++; $display("FAIL frame_period_div1 pulses=%0d want 4 spaced 128", fc_q.size()); end
  endtask

  // Reset asserted at pixel (5,2), held 3 cycles, then clean restart at (0,0).
  task automatic test_midreset();
    while (c < 588) step();
    checks++; if (x_a !== P_WIDTH'(5) || y_a !== P_WIDTH'(2)) begin failures++;
      $display("FAIL midreset_pos got=%0d,%0d want=5,2", x_a, y_a); end
    rst_n = 1'b0;
    #1;
    checks++; if ({pe_a, v_a, hs_a, vs_a, fs_a, x_a == '0, y_a == '0} !== 7'b0011011) begin failures++;
      $display("FAIL midreset_immediate got=%b want=0011011", {pe_a, v_a, hs_a, vs_a, fs_a, x_a == '0, y_a == '0}); end
    checks++; if ({v_b, hs_b, vs_b, hs_d, vs_d} !== 5'b01100) begin failures++;
      $display("FAIL midreset_pipe_pol got=%b want=01100", {v_b, hs_b, vs_b, hs_d, vs_d}); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({pe_a, v_a, fs_a, x_a == '0} !== 4'b0001) begin failures++;
      $display("FAIL midreset_held got=%b want=0001", {pe_a, v_a, fs_a, x_a == '0}); end
    rst_n = 1'b1;
    c = 0;
    step();
    checks++; if ({pe_a, fs_a, x_a == '0, y_a == '0} !== 4'b1011) begin failures++;
      $display("FAIL restart_edge1 got=%b want=1011", {pe_a, fs_a, x_a == '0, y_a == '0}); end
    step();
    checks++; if ({fs_a, v_a, x_a == '0, y_a == '0, v_b, hs_b} !== 6'b111101) begin failures++;
      $display("FAIL restart_edge2 got=%b want=111101", {fs_a, v_a, x_a == '0, y_a == '0, v_b, hs_b}); end
    step();
    step();
    checks++; if (fs_a !== 1'b0 || x_a !== P_WIDTH'(1) || y_a !== '0) begin failures++;
      $display("FAIL restart_second_pixel fs=%b x=%0d y=%0d want 0,1,0", fs_a, x_a, y_a); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_frames();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
